// File: rtl/id_ex_if.sv
// ----------------------------------------------------------------------------
// id_ex_if: bundle of the signals between the ID stage, the ID/EX pipeline
// register and the EX stage.
//
//   ID side (driven by master, read by slave):
//     stall_i, flush_i, valid_i, data1_i, data2_i, imm_i, ALUCtrl_i,
//     ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
//     RS_i, RT_i, RD_i, uses_rt_i
//   EX side (driven by slave, read by master):
//     valid_o, data1_o, data2_o, imm_o, ALUCtrl_o, ALUSrc_o, RegWrite_o,
//     MemRead_o, MemWrite_o, MemtoReg_o, RS_o, RT_o, RD_o,
//     hazard_o (combinational load-use detect), bubble_cnt_o
// ----------------------------------------------------------------------------
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [DATA_W-1:0] imm_i;
    logic [2:0]        ALUCtrl_i;
    logic              ALUSrc_i;
    logic              RegWrite_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              MemtoReg_i;
    logic [REG_W-1:0]  RS_i;
    logic [REG_W-1:0]  RT_i;
    logic [REG_W-1:0]  RD_i;
    logic              uses_rt_i;

    logic              valid_o;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [DATA_W-1:0] imm_o;
    logic [2:0]        ALUCtrl_o;
    logic              ALUSrc_o;
    logic              RegWrite_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              MemtoReg_o;
    logic [REG_W-1:0]  RS_o;
    logic [REG_W-1:0]  RT_o;
    logic [REG_W-1:0]  RD_o;
    logic              hazard_o;
    logic [15:0]       bubble_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i, data1_i, data2_i, imm_i, ALUCtrl_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
               RS_i, RT_i, RD_i, uses_rt_i,
        input  valid_o, data1_o, data2_o, imm_o, ALUCtrl_o, ALUSrc_o,
               RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
               RS_o, RT_o, RD_o, hazard_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, data1_i, data2_i, imm_i, ALUCtrl_i,
               ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
               RS_i, RT_i, RD_i, uses_rt_i,
        output valid_o, data1_o, data2_o, imm_o, ALUCtrl_o, ALUSrc_o,
               RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
               RS_o, RT_o, RD_o, hazard_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ----------------------------------------------------------------------------
// id_ex_reg: ID/EX pipeline register with load-use hazard detection and
// bubble insertion.
//
//   clk_i  : single clock, rising edge
//   rst_i  : synchronous, active-high reset (clears every register)
//   bus    : id_ex_if.slave -- ID-side inputs, EX-side registered outputs,
//            combinational hazard_o and saturating bubble_cnt_o
//
// Edge priority: reset > stall (hold) > bubble (flush or hazard) > load.
// ----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic   clk_i,
    input logic   rst_i,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [2:0]        alu_ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } stage_t;

    stage_t      stage_q, stage_d, incoming;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        hazard;
    logic        bubble;

    assign incoming = '{
        valid:      bus.valid_i,
        data1:      bus.data1_i,
        data2:      bus.data2_i,
        imm:        bus.imm_i,
        alu_ctrl:   bus.ALUCtrl_i,
        alu_src:    bus.ALUSrc_i,
        reg_write:  bus.RegWrite_i,
        mem_read:   bus.MemRead_i,
        mem_write:  bus.MemWrite_i,
        mem_to_reg: bus.MemtoReg_i,
        rs:         bus.RS_i,
        rt:         bus.RT_i,
        rd:         bus.RD_i
    };

    // A load sitting in EX whose destination the ID instruction reads.
    // Destination 0 is the hardwired zero register and never conflicts.
    assign hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) &
                    bus.valid_i &
                    ((stage_q.rd == bus.RS_i) |
                     (bus.uses_rt_i & (stage_q.rd == bus.RT_i)));

    assign bubble = bus.flush_i | hazard;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!bus.stall_i) begin
            if (bubble) begin
                // An all-zero stage is a harmless NOP: no write, no memory access.
                stage_d = '0;
                if (bubble_cnt_q != 16'hFFFF) begin
                    bubble_cnt_d = bubble_cnt_q + 16'd1;
                end
            end else begin
                stage_d = incoming;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
        if (rst_i) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.valid_o      = stage_q.valid;
    assign bus.data1_o      = stage_q.data1;
    assign bus.data2_o      = stage_q.data2;
    assign bus.imm_o        = stage_q.imm;
    assign bus.ALUCtrl_o    = stage_q.alu_ctrl;
    assign bus.ALUSrc_o     = stage_q.alu_src;
    assign bus.RegWrite_o   = stage_q.reg_write;
    assign bus.MemRead_o    = stage_q.mem_read;
    assign bus.MemWrite_o   = stage_q.mem_write;
    assign bus.MemtoReg_o   = stage_q.mem_to_reg;
    assign bus.RS_o         = stage_q.rs;
    assign bus.RT_o         = stage_q.rt;
    assign bus.RD_o         = stage_q.rd;
    assign bus.hazard_o     = hazard;
    assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_reg: randomized self-checking bench for id_ex_reg. A behavioural
// model of the EX-side contents tracks what every output must be; directed
// scenarios add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic clk;
    logic rst;

    id_ex_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    id_ex_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently held in EX.
    typedef struct {
        bit        valid;
        bit [31:0] d1, d2, imm;
        bit [2:0]  alu;
        bit        src, rw, mr, mw, m2r;
        bit [4:0]  rs, rt, rd;
    } instr_t;

    instr_t   m;
    bit [15:0] m_cnt;
    int        checks;
    int        errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t nop();
        instr_t n;
        n = '{default: 0};
        return n;
    endfunction

    // Load-use rule applied to the model's EX instruction and the live ID inputs.
    function automatic bit model_hazard();
        bit reads_dest;
        if (!(m.valid && m.mr && m.rd != 0 && bus.valid_i)) return 1'b0;
        reads_dest = (m.rd == bus.RS_i) || (bus.uses_rt_i && m.rd == bus.RT_i);
        return reads_dest;
    endfunction

    function automatic instr_t from_inputs();
        instr_t n;
        n.valid = bus.valid_i;   n.d1 = bus.data1_i;  n.d2 = bus.data2_i;
        n.imm   = bus.imm_i;     n.alu = bus.ALUCtrl_i;
        n.src   = bus.ALUSrc_i;  n.rw = bus.RegWrite_i; n.mr = bus.MemRead_i;
        n.mw    = bus.MemWrite_i; n.m2r = bus.MemtoReg_i;
        n.rs    = bus.RS_i;      n.rt = bus.RT_i;     n.rd = bus.RD_i;
        return n;
    endfunction

    task automatic compare_all();
        check("valid_o",      bus.valid_o,      m.valid);
        check("data1_o",      bus.data1_o,      m.d1);
        check("data2_o",      bus.data2_o,      m.d2);
        check("imm_o",        bus.imm_o,        m.imm);
        check("ALUCtrl_o",    bus.ALUCtrl_o,    m.alu);
        check("ALUSrc_o",     bus.ALUSrc_o,     m.src);
        check("RegWrite_o",   bus.RegWrite_o,   m.rw);
        check("MemRead_o",    bus.MemRead_o,    m.mr);
        check("MemWrite_o",   bus.MemWrite_o,   m.mw);
        check("MemtoReg_o",   bus.MemtoReg_o,   m.m2r);
        check("RS_o",         bus.RS_o,         m.rs);
        check("RT_o",         bus.RT_o,         m.rt);
        check("RD_o",         bus.RD_o,         m.rd);
        check("bubble_cnt_o", bus.bubble_cnt_o, m_cnt);
    endtask

    // One clock: check hazard_o mid-cycle, advance the model across the edge,
    // then check every registered output just after the edge.
    task automatic step();
        bit hz;
        @(negedge clk);
        hz = model_hazard();
        check("hazard_o", bus.hazard_o, hz);
        @(posedge clk);
        if (rst) begin
            m = nop();
            m_cnt = 0;
        end else if (bus.stall_i) begin
            // hold
        end else if (bus.flush_i || hz) begin
            m = nop();
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        end else begin
            m = from_inputs();
        end
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.stall_i = 0; bus.flush_i = 0; bus.valid_i = 0;
        bus.data1_i = 0; bus.data2_i = 0; bus.imm_i = 0; bus.ALUCtrl_i = 0;
        bus.ALUSrc_i = 0; bus.RegWrite_i = 0; bus.MemRead_i = 0;
        bus.MemWrite_i = 0; bus.MemtoReg_i = 0;
        bus.RS_i = 0; bus.RT_i = 0; bus.RD_i = 0; bus.uses_rt_i = 0;
    endtask

    task automatic random_inputs();
        bus.stall_i    = ($urandom_range(0, 5) == 0);
        bus.flush_i    = ($urandom_range(0, 7) == 0);
        bus.valid_i    = ($urandom_range(0, 3) != 0);
        bus.data1_i    = $urandom;
        bus.data2_i    = $urandom;
        bus.imm_i      = $urandom;
        bus.ALUCtrl_i  = 3'($urandom_range(0, 4));
        bus.ALUSrc_i   = 1'($urandom);
        bus.RegWrite_i = 1'($urandom);
        bus.MemRead_i  = ($urandom_range(0, 1) == 0);
        bus.MemWrite_i = 1'($urandom);
        bus.MemtoReg_i = 1'($urandom);
        // Small index range makes RS/RT/RD collisions (and index 0) frequent.
        bus.RS_i       = 5'($urandom_range(0, 5));
        bus.RT_i       = 5'($urandom_range(0, 5));
        bus.RD_i       = 5'($urandom_range(0, 5));
        bus.uses_rt_i  = 1'($urandom);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m      = nop();
        m_cnt  = 0;
        idle_inputs();

        // Bring registers out of X, then check reset behaviour through the model.
        rst = 1;
        @(posedge clk);
        #1;
        bus.stall_i = 1; bus.flush_i = 1;
        step();
        check("reset_valid", bus.valid_o, 0);
        check("reset_cnt",   bus.bubble_cnt_o, 0);
        rst = 0;
        idle_inputs();

        // Plain load.
        bus.valid_i = 1; bus.data1_i = 32'h5; bus.data2_i = 32'h3;
        bus.ALUCtrl_i = 3'b011; bus.RegWrite_i = 1; bus.RD_i = 5'd8;
        step();
        check("load_data1", bus.data1_o, 32'h5);
        check("load_data2", bus.data2_o, 32'h3);
        check("load_alu",   bus.ALUCtrl_o, 3'b011);
        check("load_rd",    bus.RD_o, 5'd8);
        check("load_valid", bus.valid_o, 1);
        check("load_cnt",   bus.bubble_cnt_o, 0);

        // Load-use: lw r9 in EX, ID reads r9 through RS.
        idle_inputs();
        bus.valid_i = 1; bus.MemRead_i = 1; bus.MemtoReg_i = 1; bus.RegWrite_i = 1;
        bus.RD_i = 5'd9;
        step();
        idle_inputs();
        bus.valid_i = 1; bus.RS_i = 5'd9; bus.RT_i = 5'd2; bus.RD_i = 5'd4;
        bus.RegWrite_i = 1; bus.data1_i = 32'h77;
        #1;
        check("lu_hazard_hi", bus.hazard_o, 1);
        step();
        check("lu_bubble_valid", bus.valid_o, 0);
        check("lu_bubble_mr",    bus.MemRead_o, 0);
        check("lu_hazard_lo",    bus.hazard_o, 0);
        check("lu_cnt",          bus.bubble_cnt_o, 1);
        step();
        check("lu_reload_rs",    bus.RS_o, 5'd9);
        check("lu_reload_valid", bus.valid_o, 1);
        check("lu_reload_data1", bus.data1_o, 32'h77);

        // Stall outranks flush and hazard.
        idle_inputs();
        step();
        bus.valid_i = 1; bus.MemRead_i = 1; bus.RD_i = 5'd9; bus.data2_i = 32'hBEEF;
        step();
        idle_inputs();
        bus.valid_i = 1; bus.RS_i = 5'd9; bus.stall_i = 1; bus.flush_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hazard", bus.hazard_o, 1);
            step();
            check("stall_hold_rd",  bus.RD_o, 5'd9);
            check("stall_hold_d2",  bus.data2_o, 32'hBEEF);
            check("stall_hold_cnt", bus.bubble_cnt_o, 1);
        end
        bus.stall_i = 0;
        step();
        check("stall_rel_valid", bus.valid_o, 0);
        check("stall_rel_cnt",   bus.bubble_cnt_o, 2);

        // Zero register and uses_rt gating.
        idle_inputs();
        bus.valid_i = 1; bus.MemRead_i = 1; bus.RD_i = 5'd0;
        step();
        idle_inputs();
        bus.valid_i = 1; bus.RS_i = 5'd0; bus.uses_rt_i = 1;
        #1;
        check("zero_reg_hazard", bus.hazard_o, 0);
        idle_inputs();
        bus.valid_i = 1; bus.MemRead_i = 1; bus.RD_i = 5'd7;
        step();
        idle_inputs();
        bus.valid_i = 1; bus.RS_i = 5'd3; bus.RT_i = 5'd7; bus.uses_rt_i = 0;
        #1;
        check("rt_unused_hazard", bus.hazard_o, 0);
        bus.uses_rt_i = 1;
        #1;
        check("rt_used_hazard", bus.hazard_o, 1);
        step();

        // Reset in the middle of a stall discards the held instruction.
        idle_inputs();
        bus.valid_i = 1; bus.data1_i = 32'h1234; bus.RD_i = 5'd3;
        step();
        bus.stall_i = 1; rst = 1;
        step();
        check("rst_stall_valid", bus.valid_o, 0);
        check("rst_stall_data1", bus.data1_o, 0);
        check("rst_stall_cnt",   bus.bubble_cnt_o, 0);
        rst = 0;
        idle_inputs();
        bus.valid_i = 1; bus.data1_i = 32'hABCD; bus.RD_i = 5'd5;
        step();
        check("post_rst_valid", bus.valid_o, 1);
        check("post_rst_data1", bus.data1_o, 32'hABCD);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            random_inputs();
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;

        // Saturation: enough flushes to reach 16'hFFFF from any start value.
        idle_inputs();
        bus.flush_i = 1; bus.valid_i = 1;
        for (int i = 0; i < 65536; i++) begin
            bus.RS_i = 5'($urandom_range(0, 5));
            step();
        end
        check("sat_reached", bus.bubble_cnt_o, 16'hFFFF);
        for (int i = 0; i < 4; i++) step();
        check("sat_held", bus.bubble_cnt_o, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
